result_framer: RTL and testbench

RESULT_FRAMER -- requirements
Module: result_framer

---
 rtl/result_framer.sv | 175 +++++++++++++++++
 tb/tb_result_framer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_framer.sv
// Result framer: serialises one 8-byte result frame (sync, type, job, 2x2 matrix, checksum)
// into a byte-wide UART transmitter using a tx_enable / tx_busy handshake.
module result_framer #(
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] job_id,
    input  logic [7:0] c11,
    input  logic [7:0] c12,
    input  logic [7:0] c21,
    input  logic [7:0] c22,
    input  logic       tx_busy,
    output logic [7:0] tx_byte,
    output logic       tx_enable,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W:0] GAP_LAST = (CNT_W + 1)'(GAP_CYCLES);
    localparam logic [CNT_W:0] ACK_LAST = (CNT_W + 1)'(ACK_TIMEOUT);
    localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       data_q [5];
    logic [7:0]       chk_q;
    logic [7:0]       tx_byte_q;
    logic             tx_enable_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [7:0]       data_in [5];
    logic [7:0]       frame_w [8];
    logic [7:0]       chk_d;
    logic [7:0]       frame_byte_d;
    logic [CNT_W:0]   cnt_inc;

    assign data_in[0] = job_id;
    assign data_in[1] = c11;
    assign data_in[2] = c12;
    assign data_in[3] = c21;
    assign data_in[4] = c22;

    // Checksum is taken from the live inputs so it is latched together with the payload.
    assign chk_d = job_id + c11 + c12 + c21 + c22;

    assign frame_w[0] = 8'hFF;
    assign frame_w[1] = 8'h02;
    assign frame_w[7] = chk_q;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_payload
            assign frame_w[gi + 2] = data_q[gi];
        end
    endgenerate

    always_comb begin
        frame_byte_d = frame_w[idx_q];
    end

    assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            chk_q       <= 8'h00;
            tx_byte_q   <= 8'h00;
            tx_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                data_q[k] <= 8'h00;
            end
        end else begin
            tx_enable_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 5; k++) begin
                            data_q[k] <= data_in[k];
                        end
                        chk_q   <= chk_d;
                        idx_q   <= 3'd0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!tx_busy) begin
                        tx_byte_q   <= frame_byte_d;
                        tx_enable_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_DONE;
                    end else if (cnt_inc == ACK_LAST) begin
                        // Transmitter never acknowledged: drop the frame.
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc[CNT_W-1:0];
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        cnt_q <= '0;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (GAP_CYCLES == 0) begin
                            state_q <= ISSUE;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt_inc == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ISSUE;
                    end else begin
                        cnt_q <= cnt_inc[CNT_W-1:0];
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_byte   = tx_byte_q;
    assign tx_enable = tx_enable_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_result_framer.sv
// Bench for result_framer: directed frames plus random frames against a byte-list frame model,
// with a 10-cycle-busy UART model that can also be told never to acknowledge.
module tb_result_framer;

    localparam int GAP = 16;
    localparam int ACK = 1023;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] job_id, c11, c12, c21, c22;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_enable;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    // UART model / monitor state
    logic [7:0] rx_q [$];
    int         gaps [$];
    int         en_count    = 0;
    int         done_cnt    = 0;
    int         err_cnt     = 0;
    int         busy_en_cnt = 0;
    int         busy_cnt    = 0;
    int         gap_run     = 0;
    bit         measuring   = 0;
    bit         ack_en      = 1;

    result_framer #(
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .job_id   (job_id),
        .c11      (c11),
        .c12      (c12),
        .c21      (c21),
        .c22      (c22),
        .tx_busy  (tx_busy),
        .tx_byte  (tx_byte),
        .tx_enable(tx_enable),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_busy   = 1'b0;
            busy_cnt  = 0;
            measuring = 0;
        end else begin
            if (done) begin
                done_cnt++;
                measuring = 0;
            end
            if (err) err_cnt++;
            if (tx_enable) begin
                en_count++;
                rx_q.push_back(tx_byte);
                if (tx_busy) busy_en_cnt++;
                if (measuring) begin
                    gaps.push_back(gap_run);
                    measuring = 0;
                end
                if (ack_en) begin
                    tx_busy  = 1'b1;
                    busy_cnt = 10;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy   = 1'b0;
                    measuring = 1;
                    gap_run   = 0;
                end
            end else if (measuring) begin
                gap_run++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Frame as a list of bytes: header, payload, then the modulo-256 sum of the payload.
    function automatic void model_frame(input logic [7:0] j, a, b, c, d, output logic [7:0] f [8]);
        int sum;
        sum  = int'(j) + int'(a) + int'(b) + int'(c) + int'(d);
        f[0] = 8'hFF;
        f[1] = 8'h02;
        f[2] = j;
        f[3] = a;
        f[4] = b;
        f[5] = c;
        f[6] = d;
        f[7] = 8'(sum % 256);
    endfunction

    // mode: 0 normal, 1 change c11 after start, 2 extra start during byte 3,
    //       3 no acknowledge (timeout), 4 reset during byte 5
    task automatic run_frame(input string tag, input logic [7:0] j, a, b, c, d, input int mode);
        logic [7:0] exp_f [8];
        int  base_en, base_done, base_err, cyc;
        bit  pulsed, finished;
        model_frame(j, a, b, c, d, exp_f);
        rx_q.delete();
        gaps.delete();
        base_en   = en_count;
        base_done = done_cnt;
        base_err  = err_cnt;
        ack_en    = (mode != 3);
        pulsed    = 0;
        finished  = 0;
        cyc       = 0;

        @(negedge clk); #1;
        job_id = j; c11 = a; c12 = b; c21 = c; c22 = d;
        start  = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check({tag, " lat1 tx_enable"}, tx_enable, 1'b0);
        check({tag, " lat1 busy"}, busy, 1'b1);
        if (mode == 1) c11 = 8'hAA;
        else begin
            job_id = 8'($urandom); c11 = 8'($urandom); c12 = 8'($urandom);
            c21 = 8'($urandom); c22 = 8'($urandom);
        end
        @(negedge clk); #1;
        check({tag, " lat2 tx_enable"}, tx_enable, 1'b1);

        while (cyc < 3000 && !finished) begin
            @(negedge clk); #1;
            cyc++;
            if (start) start = 1'b0;
            if (done_cnt != base_done || err_cnt != base_err) begin
                finished = 1;
            end else if (mode == 2 && !pulsed && en_count - base_en == 3) begin
                start  = 1'b1;
                job_id = 8'($urandom); c11 = 8'($urandom);
                pulsed = 1;
            end else if (mode == 4 && !pulsed && en_count - base_en == 5) begin
                pulsed = 1;
                #2 rst_n = 1'b0;
                #1;
                check({tag, " async tx_byte"}, tx_byte, 8'h00);
                check({tag, " async tx_enable"}, tx_enable, 1'b0);
                check({tag, " async busy"}, busy, 1'b0);
                check({tag, " async done"}, done, 1'b0);
                check({tag, " async err"}, err, 1'b0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (8) @(negedge clk);
                #1;
                check({tag, " no done after reset"}, done_cnt - base_done, 0);
                check({tag, " no err after reset"}, err_cnt - base_err, 0);
                check({tag, " idle after reset"}, busy, 1'b0);
                return;
            end
        end
        if (!finished) begin
            check({tag, " completion within budget"}, 0, 1);
            ack_en = 1;
            return;
        end

        if (mode == 3) begin
            check({tag, " err pulse"}, err, 1'b1);
            check({tag, " busy low at err"}, busy, 1'b0);
            check({tag, " timeout not early"}, (cyc >= ACK - 1), 1);
            check({tag, " timeout not late"}, (cyc <= ACK + 1), 1);
            check({tag, " one byte issued"}, en_count - base_en, 1);
            repeat (4) @(negedge clk);
            #1;
            check({tag, " single err"}, err_cnt - base_err, 1);
            check({tag, " no done"}, done_cnt - base_done, 0);
            ack_en = 1;
            return;
        end

        check({tag, " busy high at done"}, busy, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        check({tag, " byte count"}, rx_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rx_q.size()) check($sformatf("%s byte%0d", tag, i), rx_q[i], exp_f[i]);
        end
        check({tag, " single done"}, done_cnt - base_done, 1);
        check({tag, " no err"}, err_cnt - base_err, 0);
        check({tag, " idle after done"}, busy, 1'b0);
        check({tag, " gap count"}, gaps.size(), 7);
        foreach (gaps[i]) begin
            check($sformatf("%s gap%0d=%0d in range", tag, i, gaps[i]),
                  (gaps[i] >= GAP && gaps[i] <= GAP + 2), 1);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        job_id = 8'h00; c11 = 8'h00; c12 = 8'h00; c21 = 8'h00; c22 = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        check("reset tx_byte", tx_byte, 8'h00);
        check("reset tx_enable", tx_enable, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("basic", 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 0);
        check("basic chk 0F", (rx_q.size() == 8) ? rx_q[7] : 8'hxx, 8'h0F);
        run_frame("wrap", 8'h80, 8'h80, 8'h40, 8'h40, 8'h01, 0);
        check("wrap chk 81", (rx_q.size() == 8) ? rx_q[7] : 8'hxx, 8'h81);
        run_frame("hold", 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 1);
        check("hold c11", (rx_q.size() == 8) ? rx_q[3] : 8'hxx, 8'h34);
        run_frame("timeout", 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 3);
        run_frame("after_to", 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 0);
        run_frame("restart", 8'h41, 8'hC2, 8'h43, 8'hE4, 8'h45, 2);
        run_frame("rst", 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 4);
        run_frame("after_rst", 8'h61, 8'hF2, 8'h63, 8'h64, 8'hD5, 0);
        for (int t = 0; t < 6; t++) begin
            run_frame($sformatf("rand%0d", t), 8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom), int'($urandom_range(0, 1)));
        end
        check("no tx_enable while tx_busy", busy_en_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
